pixel_buffer_responder: RTL and testbench
=========================================

Name: pixel_buffer_responder

Overview:
Avalon-MM pipelined read responder that serves the VGA pixel DMA master from an on-chip single-port frame buffer RAM. It sits on the pixel_dma_master bus and answers its reads with fixed latency, including readdatavalid. A second Avalon-MM slave port lets the CPU write pixels. A round-robin arbiter with lock support shares the single RAM port between the two masters.

Parameters:
DEPTH, 19200, number of 16-bit pixel words in the buffer (e.g. 160x120).
AW, 15, CPU word-address width; must satisfy 2^AW >= DEPTH.
ADDR_BASE, 32'h0800_0000, byte address of word 0 on the pixel DMA port.
READ_LATENCY, 2, cycles from accepted read to readdatavalid; legal range 2..4.

Ports:
sys_clk_clk  in  1  single clock for all logic.
sys_reset_reset_n  in  1  asynchronous active-low reset.
pixel_dma_master_address  in  32  byte address from the pixel DMA.
pixel_dma_master_read  in  1  read request.
pixel_dma_master_lock  in  1  holds read-side grant while high.
pixel_dma_master_waitrequest  out  1  read request not accepted this cycle.
pixel_dma_master_readdata  out  16  pixel data (RGB565).
pixel_dma_master_readdatavalid  out  1  readdata valid this cycle.
cpu_slave_address  in  AW  word index.
cpu_slave_write  in  1  write request.
cpu_slave_writedata  in  16  pixel data.
cpu_slave_byteenable  in  2  per-byte write enable.
cpu_slave_waitrequest  out  1  write not accepted this cycle.

Behaviour:
- Reset (asynchronous, reset_n low):
  - readdatavalid=0, readdata=0, all latency pipeline stages invalid.
  - Internal rdy=0, so both waitrequests are 1.
  - prio=READ, lock_hold=0.
  - RAM contents are not reset.
- rdy sets on the first rising edge after reset_n goes high. Both waitrequests stay 1 until then.
- Grant (combinational, only when rdy=1):
  - Read only requests: read wins.
  - Write only requests: write wins.
  - Both request: read wins if lock_hold=1, otherwise the side indicated by prio wins.
- waitrequest outputs:
  - pixel_dma_master_waitrequest = read & ~read_grant.
  - cpu_slave_waitrequest = write & ~write_grant.
  - Each is 0 when its side is not requesting (and rdy=1).
- Registered arbitration state:
  - After a contested cycle where lock_hold=0, prio is set to the loser.
  - lock_hold sets when a read is granted with lock=1.
  - lock_hold clears in any cycle where lock is sampled 0.
- Read acceptance:
  - Accepted read: idx = (address - ADDR_BASE) >> 1. address[0] is ignored.
  - In range when ADDR_BASE <= address < ADDR_BASE + 2*DEPTH: RAM is read at idx.
  - Out of range: no RAM access; the response data is forced to 16'h0000.
- Read response:
  - Every accepted read produces exactly one readdatavalid pulse, exactly READ_LATENCY cycles after the acceptance edge.
  - Responses come back in order. There is no response backpressure.
  - Back-to-back accepted reads give back-to-back valid cycles.
  - readdata holds its last value when readdatavalid=0.
- Write:
  - Accepted write updates the RAM byte [15:8] if byteenable[1] and byte [7:0] if byteenable[0].
  - cpu_slave_address >= DEPTH: the write is accepted and dropped.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- RAM: single port, one access per cycle; synchronous read, with extra pipeline registers making up READ_LATENCY.
- Reset mid-operation: in-flight responses are discarded and no readdatavalid is produced for them; the first post-reset request behaves as after power-up.

Test Plan:
- Reset release: hold reset_n=0 with read=1 -> waitrequest=1, readdatavalid=0. Release -> first read is accepted one cycle after the release edge, and readdatavalid follows READ_LATENCY=2 cycles later.
- CPU write then read: write 16'hF800, be=2'b11 at index 5; then DMA read at ADDR_BASE+10 -> readdata=16'hF800 two cycles after acceptance. Then write 16'h001F with be=2'b01 -> the next read returns 16'hF81F.
- Burst: 8 consecutive reads at ADDR_BASE..ADDR_BASE+14 with write idle -> no waitrequest, 8 consecutive readdatavalid cycles with the in-order data written earlier.
- Contention: read and write held continuously, lock=0 -> grants alternate R,W,R,W starting with R; each waitrequest deasserts on alternate cycles.
- Lock: as in the contention case but lock=1 for 4 reads -> 4 consecutive read grants with cpu_slave_waitrequest=1. lock=0 on the next cycle -> the write is granted.
- Out of range: read at ADDR_BASE+2*DEPTH and at ADDR_BASE-2 -> each is accepted and returns readdatavalid with 16'h0000. Reset asserted with 2 reads in flight -> no readdatavalid is produced for them.

Source files
------------

// File: rtl/pixel_buffer_responder.sv
// Avalon-MM fixed-latency pixel read responder with a CPU write port,
// sharing one single-port frame buffer RAM through a round-robin arbiter with lock.
module pixel_buffer_responder #(
    parameter int unsigned DEPTH        = 19200,
    parameter int unsigned AW           = 15,
    parameter logic [31:0] ADDR_BASE    = 32'h0800_0000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic          sys_clk_clk,
    input  logic          sys_reset_reset_n,
    input  logic [31:0]   pixel_dma_master_address,
    input  logic          pixel_dma_master_read,
    input  logic          pixel_dma_master_lock,
    output logic          pixel_dma_master_waitrequest,
    output logic [15:0]   pixel_dma_master_readdata,
    output logic          pixel_dma_master_readdatavalid,
    input  logic [AW-1:0] cpu_slave_address,
    input  logic          cpu_slave_write,
    input  logic [15:0]   cpu_slave_writedata,
    input  logic [1:0]    cpu_slave_byteenable,
    output logic          cpu_slave_waitrequest
);

    localparam int unsigned DW         = 16;
    localparam int unsigned NX         = READ_LATENCY - 1;
    localparam logic [31:0] SPAN       = 32'(2 * DEPTH);
    localparam logic        PRIO_READ  = 1'b0;
    localparam logic        PRIO_WRITE = 1'b1;

    logic          rdy;
    logic          prio;
    logic          lock_hold;
    logic          read_grant;
    logic          write_grant;
    logic          contested;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] rd_idx;
    logic          wr_ok;
    logic          unused_offset_bits;

    // Single RAM port: read wins when uncontested, when locked, or when it holds priority
    always_comb begin
        read_grant  = 1'b0;
        write_grant = 1'b0;
        if (rdy) begin
            if (pixel_dma_master_read && cpu_slave_write) begin
                if (lock_hold || prio == PRIO_READ) begin
                    read_grant = 1'b1;
                end else begin
                    write_grant = 1'b1;
                end
            end else begin
                read_grant  = pixel_dma_master_read;
                write_grant = cpu_slave_write;
            end
        end
    end

    assign contested                    = rdy & pixel_dma_master_read & cpu_slave_write;
    assign pixel_dma_master_waitrequest = ~rdy | (pixel_dma_master_read & ~read_grant);
    assign cpu_slave_waitrequest        = ~rdy | (cpu_slave_write & ~write_grant);

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            rdy       <= 1'b0;
            prio      <= PRIO_READ;
            lock_hold <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (contested && !lock_hold) begin
                prio <= read_grant ? PRIO_WRITE : PRIO_READ;
            end
            if (!pixel_dma_master_lock) begin
                lock_hold <= 1'b0;
            end else if (read_grant) begin
                lock_hold <= 1'b1;
            end
        end
    end

    // Byte address to word index; bit 0 of the byte address is ignored
    assign offset             = pixel_dma_master_address - ADDR_BASE;
    assign in_range           = (pixel_dma_master_address >= ADDR_BASE) && (offset < SPAN);
    assign rd_idx             = offset[AW:1];
    assign unused_offset_bits = ^{offset[31:AW+1], offset[0]};
    assign wr_ok              = 32'(cpu_slave_address) < DEPTH;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;

    always_ff @(posedge sys_clk_clk) begin
        if (write_grant && wr_ok) begin
            if (cpu_slave_byteenable[1]) mem[cpu_slave_address][15:8] <= cpu_slave_writedata[15:8];
            if (cpu_slave_byteenable[0]) mem[cpu_slave_address][7:0]  <= cpu_slave_writedata[7:0];
        end
        if (read_grant && in_range) begin
            ram_q <= mem[rd_idx];
        end
    end

    logic          s1_valid;
    logic          s1_zero;
    logic [DW-1:0] s1_data;

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            s1_valid <= read_grant;
            s1_zero  <= ~in_range;
        end
    end

    assign s1_data = s1_zero ? '0 : ram_q;

    // Delay line after the RAM; each stage only loads on valid so the last one holds readdata
    logic [NX-1:0] pv;
    logic [DW-1:0] pd [NX];

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            pv <= '0;
            for (int k = 0; k < NX; k++) pd[k] <= '0;
        end else begin
            pv[0] <= s1_valid;
            if (s1_valid) pd[0] <= s1_data;
            for (int k = 1; k < NX; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end

    assign pixel_dma_master_readdatavalid = pv[NX-1];
    assign pixel_dma_master_readdata      = pd[NX-1];

endmodule

// File: tb/tb_pixel_buffer_responder.sv
// Self-checking bench: a transaction-level model of the responder checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pixel_buffer_responder;

    localparam int unsigned DEPTH = 19200;
    localparam int unsigned AW    = 15;
    localparam int unsigned L     = 2;
    localparam logic [31:0] BASE  = 32'h0800_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   dma_addr = '0;
    logic          dma_read = 1'b0;
    logic          dma_lock = 1'b0;
    logic          dma_wait;
    logic [15:0]   rd;
    logic          rdv;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_write = 1'b0;
    logic [15:0]   cpu_wdata = '0;
    logic [1:0]    cpu_be = '0;
    logic          cpu_wait;

    always #5 clk = ~clk;

    pixel_buffer_responder #(
        .DEPTH(DEPTH), .AW(AW), .ADDR_BASE(BASE), .READ_LATENCY(L)
    ) dut (
        .sys_clk_clk                    (clk),
        .sys_reset_reset_n              (rst_n),
        .pixel_dma_master_address       (dma_addr),
        .pixel_dma_master_read          (dma_read),
        .pixel_dma_master_lock          (dma_lock),
        .pixel_dma_master_waitrequest   (dma_wait),
        .pixel_dma_master_readdata      (rd),
        .pixel_dma_master_readdatavalid (rdv),
        .cpu_slave_address              (cpu_addr),
        .cpu_slave_write                (cpu_write),
        .cpu_slave_writedata            (cpu_wdata),
        .cpu_slave_byteenable           (cpu_be),
        .cpu_slave_waitrequest          (cpu_wait)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [15:0] data; bit known; } rsp_t;

    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_rdy = 0;
    bit          m_prio_write = 0;
    bit          m_lock_hold = 0;
    int          cyc = 0;
    rsp_t        m_q[$];
    logic [15:0] m_last = '0;
    bit          m_last_known = 1;
    bit          rw, ww, contest;
    longint      off;
    int          widx;
    rsp_t        r;

    function automatic bit read_wins();
        return m_rdy && dma_read && (!cpu_write || m_lock_hold || !m_prio_write);
    endfunction

    function automatic bit write_wins();
        return m_rdy && cpu_write && !read_wins();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy = 0; m_prio_write = 0; m_lock_hold = 0;
            m_q.delete(); m_last = '0; m_last_known = 1;
        end else begin
            cyc++;
            rw = read_wins();
            ww = write_wins();
            contest = m_rdy && dma_read && cpu_write;
            if (rw) begin
                off = longint'(dma_addr) - longint'(BASE);
                r.due = cyc + int'(L) - 1;
                if (off >= 0 && off < 2 * longint'(DEPTH)) begin
                    r.data  = m_mem[int'(off / 2)];
                    r.known = m_known[int'(off / 2)];
                end else begin
                    r.data = '0; r.known = 1;
                end
                m_q.push_back(r);
            end
            if (ww && 32'(cpu_addr) < DEPTH) begin
                widx = int'(cpu_addr);
                if (cpu_be[1]) m_mem[widx][15:8] = cpu_wdata[15:8];
                if (cpu_be[0]) m_mem[widx][7:0]  = cpu_wdata[7:0];
                if (cpu_be == 2'b11) m_known[widx] = 1;
            end
            if (contest && !m_lock_hold) m_prio_write = rw;
            if (!dma_lock) m_lock_hold = 0;
            else if (rw) m_lock_hold = 1;
            m_rdy = 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("dma_waitrequest", 32'(dma_wait), 32'(!m_rdy || (dma_read && !read_wins())));
        chk("cpu_waitrequest", 32'(cpu_wait), 32'(!m_rdy || (cpu_write && !write_wins())));
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            chk("readdatavalid", 32'(rdv), 32'd1);
            if (m_q[0].known) chk("readdata", 32'(rd), 32'(m_q[0].data));
            m_last       = m_q[0].data;
            m_last_known = m_q[0].known;
            void'(m_q.pop_front());
        end else begin
            chk("readdatavalid_idle", 32'(rdv), 32'd0);
            if (m_last_known) chk("readdata_hold", 32'(rd), 32'(m_last));
        end
    end

    // ---------------- directed stimulus ----------------
    bit          cap_en = 0;
    logic [15:0] cap_q[$];

    always @(negedge clk) if (cap_en && rdv) cap_q.push_back(rd);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input int idx, input logic [15:0] d, input logic [1:0] be);
        cpu_addr = AW'(idx); cpu_wdata = d; cpu_be = be; cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    task automatic dma_rd(input logic [31:0] a, input logic [15:0] exp, input string nm);
        bit got = 0;
        dma_addr = a; dma_read = 1'b1;
        step();
        dma_read = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (rdv) begin
                got = 1;
                chk(nm, 32'(rd), 32'(exp));
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no readdatavalid expected one within 8 cycles", nm);
        end
        step();
    endtask

    logic [15:0] wr_vals   [8] = '{16'h1000, 16'h1111, 16'h1222, 16'h1333,
                                   16'h1444, 16'h1555, 16'h1666, 16'h1777};
    logic [15:0] burst_exp [8] = '{16'h1000, 16'h1111, 16'h1222, 16'h1333,
                                   16'h1444, 16'hF81F, 16'h1666, 16'h1777};
    logic [3:0]  dw, cw;

    initial begin
        #2;
        rst_n = 1'b0; dma_read = 1'b1; dma_addr = BASE;
        repeat (3) step();
        @(negedge clk);
        chk("rst_dma_wait", 32'(dma_wait), 32'd1);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd1);
        chk("rst_rdv", 32'(rdv), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_rdy_wait", 32'(dma_wait), 32'd1);
        step();
        @(negedge clk);
        chk("post_rdy_wait", 32'(dma_wait), 32'd0);
        step();
        dma_read = 1'b0;
        @(negedge clk);
        chk("lat1_rdv", 32'(rdv), 32'd0);
        step();
        @(negedge clk);
        chk("lat2_rdv", 32'(rdv), 32'd1);
        step();

        for (int k = 0; k < 8; k++) cpu_wr(k, wr_vals[k], 2'b11);
        cpu_wr(5, 16'hF800, 2'b11);
        dma_rd(BASE + 32'd10, 16'hF800, "rd_f800");
        cpu_wr(5, 16'h001F, 2'b01);
        dma_rd(BASE + 32'd10, 16'hF81F, "rd_f81f");
        dma_rd(BASE + 32'd11, 16'hF81F, "rd_odd_addr");
        cpu_wr(int'(DEPTH) - 1, 16'h07E0, 2'b11);
        dma_rd(BASE + 32'(2 * (DEPTH - 1)), 16'h07E0, "rd_last_word");
        dma_rd(BASE + 32'(2 * DEPTH) - 32'd1, 16'h07E0, "rd_last_odd");
        cpu_wr(int'(DEPTH), 16'hBEEF, 2'b11);

        // Burst of 8 back-to-back reads
        cap_q.delete(); cap_en = 1;
        for (int k = 0; k < 8; k++) begin
            dma_addr = BASE + 32'(2 * k); dma_read = 1'b1;
            step();
        end
        dma_read = 1'b0;
        repeat (4) step();
        cap_en = 0;
        chk("burst_count", 32'(cap_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < cap_q.size(); k++) chk("burst_data", 32'(cap_q[k]), 32'(burst_exp[k]));

        // Contention without lock alternates R,W,R,W
        dma_addr = BASE; dma_read = 1'b1;
        cpu_addr = AW'(100); cpu_wdata = 16'hABCD; cpu_be = 2'b11; cpu_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dw[i] = dma_wait; cw[i] = cpu_wait;
            step();
        end
        dma_read = 1'b0; cpu_write = 1'b0;
        chk("contend_dma_wait", 32'(dw), 32'h0000000A);
        chk("contend_cpu_wait", 32'(cw), 32'h00000005);
        repeat (3) step();

        // Lock keeps the read side granted
        dma_read = 1'b1; cpu_write = 1'b1; dma_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dw[i] = dma_wait; cw[i] = cpu_wait;
            step();
        end
        dma_lock = 1'b0; dma_read = 1'b0;
        chk("lock_dma_wait", 32'(dw), 32'd0);
        chk("lock_cpu_wait", 32'(cw), 32'h0000000F);
        @(negedge clk);
        chk("unlock_cpu_wait", 32'(cpu_wait), 32'd0);
        step();
        cpu_write = 1'b0;
        repeat (3) step();

        dma_rd(BASE + 32'(2 * DEPTH), 16'h0000, "oor_high");
        dma_rd(BASE - 32'd2, 16'h0000, "oor_low");
        dma_rd(BASE + 32'd200, 16'hABCD, "rd_contended_write");

        // Reset with two reads accepted and no response sampled yet
        cap_q.delete(); cap_en = 1;
        dma_addr = BASE; dma_read = 1'b1;
        step();
        dma_addr = BASE + 32'd2;
        step();
        rst_n = 1'b0; dma_read = 1'b0;
        repeat (4) step();
        cap_en = 0;
        chk("rst_flush_count", 32'(cap_q.size()), 32'd0);
        rst_n = 1'b1;
        step();
        dma_rd(BASE + 32'd10, 16'hF81F, "post_rst_read");

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
